// File: rtl/audio_adc_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants and FSM state type for the codec audio
//               serial link (receive side).
// Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

  localparam int   AUDIO_DATA_WIDTH = 16;
  localparam int   REF_CLK          = 18432000;
  localparam int   SAMPLE_RATE      = 48000;

  // LRCK level that marks the left channel
  localparam logic LR_LEFT          = 1'b1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SHIFT_L   = 2'd1,
    SHIFT_R   = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_adc_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_adc_rx_if
// Description : Stereo PCM pair handshake between the ADC receiver (master)
//               and the DSP consumer (slave).
//   left, right : held stereo pair, two's complement
//   valid       : a pair is held
//   ready       : consumer takes the pair when high with valid
//   clr_err     : clears the sticky flags
//   overrun     : sticky, a pair was dropped
//   frame_err   : sticky, a channel period was short of bits
// Revision    : 1.0  initial release
// ============================================================================
interface audio_adc_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] left;
  logic [DATA_WIDTH-1:0] right;
  logic                  valid;
  logic                  ready;
  logic                  clr_err;
  logic                  overrun;
  logic                  frame_err;

  modport master (
    output left, right, valid, overrun, frame_err,
    input  ready, clr_err
  );

  modport slave (
    input  left, right, valid, overrun, frame_err,
    output ready, clr_err
  );
endinterface
`default_nettype wire

// File: rtl/audio_adc_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : audio_sync_edge
// Description : Multi-stage synchroniser followed by one history flop.
//   clk, rst  : system clock, synchronous active-high reset
//   async_in  : asynchronous input
//   level     : synchronised level
//   rise      : synchronised 0->1 transition (one cycle)
//   any_edge  : synchronised transition of either direction (one cycle)
// Revision    : 1.0  initial release
// ============================================================================
module audio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic any_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level    = sync_q[SYNC_STAGES-1];
  assign rise     = level & ~hist_q;
  assign any_edge = level ^ hist_q;

endmodule
`default_nettype wire

// File: rtl/audio_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : audio_adc_rx
// Description : Deserialises the codec ADC line (left-justified, MSB first,
//               LRCK high = left) into 16-bit stereo pairs held behind a
//               valid/ready register with overrun and framing-error flags.
//   iCLK_18_4    : system clock
//   iRST         : synchronous active-high reset
//   iAUD_BCK     : bit clock (same net the FPGA drives to the codec)
//   iAUD_ADCLRCK : ADC word clock, 1 = left
//   iAUD_ADCDAT  : serial ADC data
//   bus          : stereo pair handshake and sticky flags (master side)
// Revision    : 1.0  initial release
// ============================================================================
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 5
) (
  input  logic             iCLK_18_4,
  input  logic             iRST,
  input  logic             iAUD_BCK,
  input  logic             iAUD_ADCLRCK,
  input  logic             iAUD_ADCDAT,
  audio_adc_rx_if.master   bus
);

  logic bck_level, bck_rise, bck_edge;
  logic lr_level, lr_rise, lr_edge;
  logic dat;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic unused_sync;

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bck_sync (
    .clk(iCLK_18_4), .rst(iRST), .async_in(iAUD_BCK),
    .level(bck_level), .rise(bck_rise), .any_edge(bck_edge)
  );

  audio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lr_sync (
    .clk(iCLK_18_4), .rst(iRST), .async_in(iAUD_ADCLRCK),
    .level(lr_level), .rise(lr_rise), .any_edge(lr_edge)
  );

  assign unused_sync = bck_level ^ bck_edge ^ lr_rise;

  // Data needs only the synchronised level, no history
  always_ff @(posedge iCLK_18_4) begin
    if (iRST) dat_sync_q <= '0;
    else      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], iAUD_ADCDAT};
  end
  assign dat = dat_sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Channel FSM
  // --------------------------------------------------------------------------
  rx_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, left_hold_q;
  logic [DATA_WIDTH-1:0] pair_left_q, pair_right_q;
  logic                  issue_q;
  logic                  cnt_full;
  logic                  chan_start, latch_left, issue_d, ferr_set;

  assign cnt_full = (cnt_q == CNT_WIDTH'(DATA_WIDTH));

  always_ff @(posedge iCLK_18_4) begin
    if (iRST) state_q <= WAIT_SYNC;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    chan_start = 1'b0;
    latch_left = 1'b0;
    issue_d    = 1'b0;
    ferr_set   = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (lr_edge && (lr_level == LR_LEFT)) begin
          state_d    = SHIFT_L;
          chan_start = 1'b1;
        end
      end
      SHIFT_L: begin
        if (lr_edge) begin
          if (cnt_full) begin
            latch_left = 1'b1;
            chan_start = 1'b1;
            state_d    = SHIFT_R;
          end else begin
            ferr_set   = 1'b1;
            state_d    = WAIT_SYNC;
          end
        end
      end
      SHIFT_R: begin
        if (lr_edge) begin
          if (cnt_full) begin
            issue_d    = 1'b1;
            chan_start = 1'b1;
            state_d    = SHIFT_L;
          end else begin
            ferr_set   = 1'b1;
            state_d    = WAIT_SYNC;
          end
        end
      end
      default: state_d = WAIT_SYNC;
    endcase
  end

  // Shift register and bit counter. A bck_rise coinciding with a channel
  // start is the MSB of the new channel, so it lands in the cleared register.
  always_ff @(posedge iCLK_18_4) begin
    if (iRST) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (chan_start) begin
      cnt_q   <= bck_rise ? CNT_WIDTH'(1) : '0;
      shift_q <= bck_rise ? DATA_WIDTH'(dat) : '0;
    end else if (ferr_set) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (bck_rise && (state_q != WAIT_SYNC) && !cnt_full) begin
      cnt_q   <= cnt_q + CNT_WIDTH'(1);
      shift_q <= {shift_q[DATA_WIDTH-2:0], dat};
    end
  end

  // The completed pair is staged for one cycle before the output register
  always_ff @(posedge iCLK_18_4) begin
    if (iRST) begin
      left_hold_q  <= '0;
      pair_left_q  <= '0;
      pair_right_q <= '0;
      issue_q      <= 1'b0;
    end else begin
      if (latch_left) left_hold_q <= shift_q;
      issue_q <= issue_d;
      if (issue_d) begin
        pair_left_q  <= left_hold_q;
        pair_right_q <= shift_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register and sticky flags
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] left_q, right_q;
  logic valid_q, overrun_q, ferr_q;
  logic xfer, ovr_set;

  assign xfer    = valid_q & bus.ready;
  assign ovr_set = issue_q & valid_q & ~bus.ready;

  always_ff @(posedge iCLK_18_4) begin
    if (iRST) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (issue_q && (!valid_q || xfer)) begin
        left_q  <= pair_left_q;
        right_q <= pair_right_q;
        valid_q <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
      // set wins over a simultaneous clear
      overrun_q <= ovr_set  | (overrun_q & ~bus.clr_err);
      ferr_q    <= ferr_set | (ferr_q    & ~bus.clr_err);
    end
  end

  assign bus.left      = left_q;
  assign bus.right     = right_q;
  assign bus.valid     = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_adc_rx
// Description : Self-checking bench for audio_adc_rx. A master serialiser
//               drives BCK/LRCK/DAT; expected pairs go into a queue and are
//               compared on every valid/ready transfer.
// Revision    : 1.0  initial release
// ============================================================================
module tb_audio_adc_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bck = 1'b0;
  logic lrck = 1'b0;
  logic dat = 1'b0;

  always #5 clk = ~clk;

  audio_adc_rx_if #(.DATA_WIDTH(16)) bus ();

  audio_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(5)) dut (
    .iCLK_18_4   (clk),
    .iRST        (rst),
    .iAUD_BCK    (bck),
    .iAUD_ADCLRCK(lrck),
    .iAUD_ADCDAT (dat),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        p_valid = 1'b0, p_xfer = 1'b0;
  logic [15:0] p_left = '0, p_right = '0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!rst && bus.valid && bus.ready) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pair_left", 32'(bus.left), 32'(e[31:16]));
        check_eq("pair_right", 32'(bus.right), 32'(e[15:0]));
      end
    end
    if (!rst && p_valid && !p_xfer && bus.valid) begin
      check_eq("hold_left", 32'(bus.left), 32'(p_left));
      check_eq("hold_right", 32'(bus.right), 32'(p_right));
    end
    p_valid = bus.valid & ~rst;
    p_xfer  = bus.valid & bus.ready;
    p_left  = bus.left;
    p_right = bus.right;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // MSB first; LRCK and DAT change with falling BCK
  task automatic send_bits(input logic lr, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bck = 1'b0; lrck = lr; dat = bits[i];
      tick(6);
      bck = 1'b1;
      tick(6);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit push);
    if (push) exp_q.push_back({l, r});
    send_bits(1'b1, 32'(l), 16);
    send_bits(1'b0, 32'(r), 16);
  endtask

  // final LRCK rise that closes the last right channel
  task automatic lr_rise();
    bck = 1'b0; lrck = 1'b1; dat = 1'b0;
    tick(6);
    bck = 1'b1;
    tick(6);
    bck = 1'b0;
    tick(6);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(1); n++; end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; bck = 1'b0; lrck = 1'b0; dat = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    bus.ready   = 1'b1;
    bus.clr_err = 1'b0;
    tick(1);

    // reset state and single frame with latency
    do_reset();
    check_eq("rst_valid", 32'(bus.valid), 32'd0);
    check_eq("rst_left", 32'(bus.left), 32'd0);
    check_eq("rst_right", 32'(bus.right), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    send_frame(16'h1234, 16'hABCD, 1'b1);
    bck = 1'b0; lrck = 1'b1; dat = 1'b0;
    n = 0;
    while (!bus.valid && n < 20) begin @(posedge clk); n++; #4; end
    check_eq("issue_latency", 32'(n), 32'd4);
    tick(6); bck = 1'b1; tick(6); bck = 1'b0; tick(6);
    drain("t1_drain");
    check_eq("t1_overrun", 32'(bus.overrun), 32'd0);
    check_eq("t1_frame_err", 32'(bus.frame_err), 32'd0);

    // eight back-to-back frames, ready tied high
    do_reset();
    bus.ready = 1'b1;
    for (int k = 0; k < 8; k++)
      send_frame(16'h8000 + 16'(k), 16'h7FFF - 16'(k), 1'b1);
    lr_rise();
    drain("t2_drain");
    check_eq("t2_overrun", 32'(bus.overrun), 32'd0);
    check_eq("t2_frame_err", 32'(bus.frame_err), 32'd0);

    // back-pressure across two frames
    do_reset();
    bus.ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 1'b1);
    send_frame(16'h3333, 16'h4444, 1'b0);
    lr_rise();
    tick(10);
    check_eq("t3_overrun", 32'(bus.overrun), 32'd1);
    check_eq("t3_valid", 32'(bus.valid), 32'd1);
    check_eq("t3_left", 32'(bus.left), 32'h1111);
    bus.clr_err = 1'b1; tick(1); bus.clr_err = 1'b0; tick(1);
    check_eq("t3_clr_overrun", 32'(bus.overrun), 32'd0);
    check_eq("t3_still_valid", 32'(bus.valid), 32'd1);
    bus.ready = 1'b1;
    drain("t3_drain");

    // truncated left channel
    do_reset();
    send_bits(1'b1, 32'h2AA, 10);
    send_bits(1'b0, 32'h0F0F, 16);
    check_eq("t4_frame_err_early", 32'(bus.frame_err), 32'd1);
    send_frame(16'h5555, 16'hAAAA, 1'b1);
    lr_rise();
    drain("t4_drain");
    check_eq("t4_frame_err", 32'(bus.frame_err), 32'd1);

    // reset in the middle of a right channel
    do_reset();
    bus.ready = 1'b0;
    send_frame(16'h0BAD, 16'hF00D, 1'b0);
    send_bits(1'b1, 32'hDEAD, 16);
    send_bits(1'b0, 32'hBE, 8);
    check_eq("t5_held_before_rst", 32'(bus.valid), 32'd1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check_eq("t5_rst_valid", 32'(bus.valid), 32'd0);
    check_eq("t5_rst_left", 32'(bus.left), 32'd0);
    check_eq("t5_rst_right", 32'(bus.right), 32'd0);
    bus.ready = 1'b1;
    send_bits(1'b0, 32'hEF, 8);
    send_frame(16'hC0DE, 16'h1357, 1'b1);
    lr_rise();
    drain("t5_drain");

    // 20 BCKs per channel, extra bits ignored
    do_reset();
    exp_q.push_back({16'hFFFF, 16'h0F0F});
    send_bits(1'b1, 32'hFFFF0, 20);
    send_bits(1'b0, 32'h0F0FF, 20);
    lr_rise();
    drain("t6_drain");
    check_eq("t6_frame_err", 32'(bus.frame_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/audio_adc_rx.md
Name: audio_adc_rx

Overview:
- Receive side of the codec audio serial link: deserialises the codec ADC data line into 16-bit left/right PCM words.
- Uses the same BCK/LRCK framing the FPGA already drives to the DAC: FPGA is master, left-justified, MSB first, LRCK high = left, 16 bits per channel, 48 kHz from 18.432 MHz.
- Presents each completed stereo pair to the Karplus-Strong/DSP logic through a valid/ready holding register with overrun and framing-error reporting.

Parameters:
- DATA_WIDTH, 16, bits captured per channel.
- SYNC_STAGES, 2, synchroniser flops on BCK, LRCK and DAT; legal range 2..3.
- CNT_WIDTH, 5, width of the per-channel BCK edge counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- iCLK_18_4  in  1  system clock, 18.432 MHz.
- iRST  in  1  synchronous reset, active-high.
- iAUD_BCK  in  1  bit clock, the same net driven to the codec.
- iAUD_ADCLRCK  in  1  ADC word clock; 1 = left, 0 = right.
- iAUD_ADCDAT  in  1  serial data from the codec.
- iREADY  in  1  consumer accepts the pair when high while oVALID is high.
- iCLR_ERR  in  1  clears the sticky flags.
- oLEFT  out  DATA_WIDTH  left sample, two's complement.
- oRIGHT  out  DATA_WIDTH  right sample, two's complement.
- oVALID  out  1  a pair is held in the output register.
- oOVERRUN  out  1  sticky; a pair was dropped.
- oFRAME_ERR  out  1  sticky; a channel period had fewer than DATA_WIDTH BCK rising edges.

Behaviour:
- Clocking and reset: one clock (iCLK_18_4). iRST is synchronous, active-high.
- Reset values: all outputs 0, all synchroniser and history flops 0, FSM in WAIT_SYNC, shift register 0, counter 0.
- Synchronisation: BCK, LRCK and DAT each pass through SYNC_STAGES flops, followed by one history flop on BCK and LRCK.
  - bck_rise = synced BCK 1 and history 0.
  - lr_edge = synced LRCK differs from its history.
- Data sampling: DAT is sampled from its synchronised copy on the bck_rise cycle. The codec changes DAT on falling BCK, so the bit is stable at rise.
- FSM states:
  - WAIT_SYNC: ignore everything until an LRCK falling-to-rising edge (start of a left channel). Then clear counter and shift register and go to SHIFT_L.
  - SHIFT_L / SHIFT_R: on each bck_rise with counter < DATA_WIDTH, shift left, insert DAT at the LSB, and increment the counter. The counter saturates at DATA_WIDTH; further bits are ignored.
  - On lr_edge in SHIFT_L:
    - If the counter equals DATA_WIDTH, latch the shift register into left_hold and go to SHIFT_R.
    - Otherwise set oFRAME_ERR and go to WAIT_SYNC.
  - On lr_edge in SHIFT_R:
    - If the counter equals DATA_WIDTH, issue a pair and go to SHIFT_L.
    - Otherwise set oFRAME_ERR and go to WAIT_SYNC.
  - Every channel transition clears the counter and shift register.
- Simultaneous lr_edge and bck_rise: lr_edge is evaluated first. The bck_rise bit is the MSB of the new channel and is shifted into the cleared register in the same cycle.
- Pair issue:
  - If oVALID is 0, or oVALID and iREADY are both 1 this cycle, load oLEFT = left_hold and oRIGHT = shift register, and set oVALID = 1 on the next edge.
  - Otherwise the held pair is kept, the new pair is dropped, and oOVERRUN is set.
- Handshake:
  - The transfer occurs on any cycle with oVALID and iREADY both high.
  - oVALID drops the following cycle unless a pair issues in that same cycle.
  - oLEFT and oRIGHT are stable while oVALID is high.
- Issue latency: oVALID rises on the 3rd iCLK_18_4 edge after the edge that first samples iAUD_ADCLRCK low-to-high at the end of the right channel (SYNC_STAGES = 2).
- Sticky flags:
  - iCLR_ERR clears both flags.
  - A set event in the same cycle as iCLR_ERR wins, so the flag stays 1.
- Reset mid-frame: the partial word is discarded, the FSM returns to WAIT_SYNC, and the first pair after reset is always a complete left/right frame.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_DATA_WIDTH = 16, REF_CLK = 18432000, SAMPLE_RATE = 48000.
  - LR_LEFT = 1'b1.
  - FSM state enum {WAIT_SYNC, SHIFT_L, SHIFT_R}.
- One sub-module, audio_sync_edge: multi-stage synchroniser plus history flop, reporting synced level, rise and any-edge. Instantiated for BCK and LRCK; the DAT path uses the level only.

Test Plan:
- Reset, then a bench-driven master serialiser (BCK period 12 clocks, 32 BCKs per frame) sends left=16'h1234, right=16'hABCD -> one pulse with oLEFT=16'h1234, oRIGHT=16'hABCD, 3 clocks after the LRCK rise; both flags 0.
- Eight consecutive frames (left=16'h8000+n, right=16'h7FFF-n) with iREADY tied 1 -> eight transfers in order with exact values, no overrun.
- iREADY held 0 across two frames -> first pair held stable, oOVERRUN=1 after the second; iCLR_ERR pulse -> oOVERRUN=0 while the held pair is still valid.
- Left channel truncated to 10 BCKs before the LRCK toggle -> oFRAME_ERR=1, no oVALID for that frame; the next complete frame (16'h5555/16'hAAAA) is delivered correctly.
- iRST asserted for 1 cycle mid right-channel -> all outputs 0; the first pair delivered is from the next full frame; the partial frame is never emitted.
- Extra BCKs (20 per channel) with data 16'hFFFF followed by 4 zero bits -> oLEFT=16'hFFFF; the extra bits are ignored.
